// File: rtl/hdc_pkg.sv
// Shared HDC constants and the chunk-scheduler state encoding, so the scheduler
// and bundler instances elaborate with matching geometry.
package hdc_pkg;

  localparam int HDC_DIM      = 10000;
  localparam int HDC_PAR_BITS = 10;
  localparam int HDC_NUM_HVS  = 17;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LAUNCH,
    WAIT_LO,
    WAIT_HI,
    WRITE,
    DRN_LO,
    DRN_HI
  } sched_state_t;

endpackage

// File: rtl/bundle_chunk_sched.sv
// Walks the bit-slice majority bundler across a D-bit hypervector, one PAR_BITS chunk
// at a time: fetch, launch, wait for the bundler handshake, write the result chunk.
module bundle_chunk_sched
  import hdc_pkg::*;
#(
  parameter int NUM_HVS  = HDC_NUM_HVS,
  parameter int PAR_BITS = HDC_PAR_BITS,
  parameter int DIM      = HDC_DIM,
  parameter int MEM_LAT  = 1,
  localparam int NUM_CHUNKS = DIM / PAR_BITS,
  localparam int CW         = $clog2(NUM_CHUNKS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [CW-1:0]       chunk_addr,
  output logic                bnd_en,
  input  logic                bnd_done,
  input  logic [PAR_BITS-1:0] bnd_out_bits,
  output logic                res_we,
  output logic [PAR_BITS-1:0] res_bits
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST   = LW'(MEM_LAT - 1);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);

  if (DIM % PAR_BITS != 0) begin : g_bad_dim
    $error("bundle_chunk_sched: DIM must be a multiple of PAR_BITS");
  end
  if (MEM_LAT < 1 || NUM_HVS < 1) begin : g_bad_cfg
    $error("bundle_chunk_sched: MEM_LAT and NUM_HVS must be >= 1");
  end

  sched_state_t  state_q, state_d;
  logic [CW-1:0] addr_q, addr_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lat_d     = lat_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = '0;
          lat_d   = '0;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (lat_q == LAT_LAST) begin
          state_d = LAUNCH;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      // The launch pulse is already on the wire this cycle, so abort must drain it.
      LAUNCH:  state_d = abort ? DRN_LO : WAIT_LO;
      WAIT_LO: begin
        if (abort)          state_d = DRN_LO;
        else if (!bnd_done) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (abort)         state_d = DRN_HI;
        else if (bnd_done) state_d = WRITE;
      end
      WRITE: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (addr_q == LAST_CHUNK) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = FETCH;
          addr_d  = addr_q + CW'(1);
          lat_d   = '0;
        end
      end
      DRN_LO: begin
        if (!bnd_done) state_d = DRN_HI;
      end
      DRN_HI: begin
        if (bnd_done) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      lat_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      lat_q     <= lat_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign bnd_en     = (state_q == LAUNCH);
  assign res_we     = (state_q == WRITE);
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign chunk_addr = addr_q;
  assign res_bits   = bnd_out_bits;

endmodule

// File: tb/tb_bundle_chunk_sched.sv
// Self-checking bench for bundle_chunk_sched with a behavioural bundler and a
// random source ROM; expectations come from the cycle-level timing rules.
module tb_bundle_chunk_sched;

  localparam int NH  = 3;
  localparam int PB  = 4;
  localparam int D   = 12;
  localparam int ML  = 1;
  localparam int NC  = D / PB;
  localparam int P   = ML + NH + 4;
  localparam int CWT = $clog2(NC);

  logic           clk = 1'b0;
  logic           rst, start, abort;
  logic           busy, done, aborted, bnd_en, bnd_done, res_we;
  logic [CWT-1:0] chunk_addr;
  logic [PB-1:0]  bnd_out_bits, res_bits;

  logic [PB-1:0]  rom [NC][NH];
  int             ones [PB];
  int             bcnt;
  int             tests = 0;
  int             fails = 0;

  always #5 clk = ~clk;

  bundle_chunk_sched #(
    .NUM_HVS (NH),
    .PAR_BITS(PB),
    .DIM     (D),
    .MEM_LAT (ML)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .chunk_addr  (chunk_addr),
    .bnd_en      (bnd_en),
    .bnd_done    (bnd_done),
    .bnd_out_bits(bnd_out_bits),
    .res_we      (res_we),
    .res_bits    (res_bits)
  );

  // Bundler stand-in: one row per cycle from the live ROM output after en,
  // one cycle to resolve, then done stays high until the next en.
  always @(posedge clk) begin
    if (rst) begin
      bnd_done     <= 1'b0;
      bnd_out_bits <= '0;
      bcnt         <= 0;
    end else if (bnd_en) begin
      bnd_done <= 1'b0;
      bcnt     <= 1;
      for (int i = 0; i < PB; i++) ones[i] <= 0;
    end else if (bcnt >= 1 && bcnt <= NH) begin
      for (int i = 0; i < PB; i++) ones[i] <= ones[i] + int'(rom[chunk_addr][bcnt-1][i]);
      bcnt <= bcnt + 1;
    end else if (bcnt == NH + 1) begin
      for (int i = 0; i < PB; i++) bnd_out_bits[i] <= (2 * ones[i] > NH);
      bnd_done <= 1'b1;
      bcnt     <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PB-1:0] maj(input int k);
    logic [PB-1:0] m;
    for (int b = 0; b < PB; b++) begin
      int c;
      c = 0;
      for (int r = 0; r < NH; r++) c += int'(rom[k][r][b]);
      m[b] = (2 * c > NH);
    end
    return m;
  endfunction

  // Cycle in which the controller is back in IDLE (and aborted is high) for an
  // abort held during cycle a of a pass started in cycle 0.
  function automatic int abort_end(input int a);
    int phase, cs, rise;
    phase = (a - 1) % P;
    if (phase < ML || phase == P - 1) return a + 1;
    cs   = a - phase;
    rise = cs + ML + NH + 2;
    return ((rise > a + 1) ? rise : a + 1) + 1;
  endfunction

  task automatic randomize_rom();
    for (int k = 0; k < NC; k++)
      for (int r = 0; r < NH; r++) rom[k][r] = PB'($urandom);
  endtask

  // start high in cycles 0..hold-1, abort high in cycle abort_at (0 = none).
  task automatic run_seq(input string name, input int n_cyc, input int hold,
                         input int abort_at, input bit abort_w_start);
    int  s [2];
    int  e [2];
    bit  ab [2];
    int  npass;
    s[0]  = 0;
    ab[0] = (abort_at > 0);
    e[0]  = ab[0] ? abort_end(abort_at) : NC * P + 1;
    npass = 1;
    if (!ab[0] && hold > e[0]) begin
      s[1] = e[0]; e[1] = e[0] + NC * P + 1; ab[1] = 1'b0; npass = 2;
    end
    start = 1'b1;
    abort = abort_w_start;
    for (int t = 1; t <= n_cyc; t++) begin
      logic          x_busy, x_en, x_we, x_done, x_ab;
      logic [31:0]   x_addr;
      @(posedge clk);
      #1;
      start = (t < hold);
      abort = (t == abort_at);
      x_busy = 0; x_en = 0; x_we = 0; x_done = 0; x_ab = 0; x_addr = 0;
      for (int p = 0; p < npass; p++) begin
        int rel;
        rel = t - s[p];
        if (t > s[p] && t < e[p]) begin
          x_busy = 1;
          x_addr = (rel - 1) / P;
          if ((rel - 1) % P == ML) x_en = 1;
          if (rel % P == 0)        x_we = 1;
        end
        if (t == e[p]) begin
          if (ab[p]) x_ab = 1; else x_done = 1;
        end
      end
      check($sformatf("%s busy@%0d", name, t), 32'(busy), 32'(x_busy));
      check($sformatf("%s bnd_en@%0d", name, t), 32'(bnd_en), 32'(x_en));
      check($sformatf("%s res_we@%0d", name, t), 32'(res_we), 32'(x_we));
      check($sformatf("%s done@%0d", name, t), 32'(done), 32'(x_done));
      check($sformatf("%s aborted@%0d", name, t), 32'(aborted), 32'(x_ab));
      if (x_busy) check($sformatf("%s addr@%0d", name, t), 32'(chunk_addr), x_addr);
      if (x_we)   check($sformatf("%s res_bits@%0d", name, t), 32'(res_bits),
                        32'(maj(int'(x_addr))));
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    randomize_rom();
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset aborted", 32'(aborted), 0);
    check("reset bnd_en", 32'(bnd_en), 0);
    check("reset res_we", 32'(res_we), 0);
    check("reset addr", 32'(chunk_addr), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Full pass with fixed majority data in chunk 0, then random data.
    rom[0][0] = 4'b1100; rom[0][1] = 4'b1010; rom[0][2] = 4'b1001;
    run_seq("pass", NC * P + 4, 1, 0, 1'b0);
    check("chunk0 majority model", 32'(maj(0)), 32'h8);
    for (int i = 0; i < 3; i++) begin
      randomize_rom();
      run_seq("rpass", NC * P + 4, 1, 0, 1'b0);
    end

    // start and abort together in IDLE: start wins.
    randomize_rom();
    run_seq("start_abort", NC * P + 4, 1, 0, 1'b1);

    // Directed aborts: FETCH, LAUNCH, WAIT_LO, WAIT_HI of chunk 1, WRITE, last WRITE.
    begin
      int dir [6] = '{1, 2, 3, 13, 8, NC * P};
      foreach (dir[i]) begin
        randomize_rom();
        run_seq($sformatf("abort%0d", dir[i]), abort_end(dir[i]) + 4, 1, dir[i], 1'b0);
      end
    end
    // A fresh start after an abort reruns from chunk 0.
    run_seq("rerun", NC * P + 4, 1, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      int a;
      a = int'($urandom_range(1, NC * P));
      randomize_rom();
      run_seq($sformatf("rabort%0d", a), abort_end(a) + 4, 1, a, 1'b0);
    end

    // start held for 40 cycles: one pass, then a second one right after done.
    randomize_rom();
    run_seq("held", 2 * (NC * P + 1) + 4, 40, 0, 1'b0);

    // Reset in the middle of chunk 1.
    start = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("pre-rst busy", 32'(busy), 1);
    check("pre-rst addr", 32'(chunk_addr), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst busy", 32'(busy), 0);
    check("rst bnd_en", 32'(bnd_en), 0);
    check("rst res_we", 32'(res_we), 0);
    check("rst addr", 32'(chunk_addr), 0);
    for (int t = 0; t < 12; t++) begin
      @(posedge clk);
      #1;
      check($sformatf("post-rst done@%0d", t), 32'(done), 0);
      check($sformatf("post-rst aborted@%0d", t), 32'(aborted), 0);
      check($sformatf("post-rst busy@%0d", t), 32'(busy), 0);
    end
    run_seq("post-rst pass", NC * P + 4, 1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
